// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: decoupling FIFO between fetch stage f2 and decode stage d1.
// Optional macro FETCH_IQ_BYPASS_EN forwards a word through an empty queue in the same cycle.
module fetch_instr_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resteer,
    input  logic             valid_in,
    input  logic [XLEN-1:0]  instr_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             exception_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [XLEN-1:0]  instr_out,
    output logic [XLEN-1:0]  pc_out,
    output logic             exception_out,
    output logic             is_compressed_out,
    input  logic             ready_in,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;

    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic            mem_exc   [DEPTH];

    logic full;
    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

`ifdef FETCH_IQ_BYPASS_EN
    assign bypass = empty & valid_in & ready_in & ~resteer;
`else
    assign bypass = 1'b0;
`endif

    // Handshake: a word moves on an edge only when its valid and the matching
    // ready are both high in that cycle; push = valid_in & ready_out,
    // pop = valid_out & ready_in. ready_out never looks at ready_in, so a full
    // queue refuses a push even while it is popping.
    assign ready_out = ~full & ~resteer;
    assign valid_out = (~empty & ~resteer) | bypass;
    assign push      = valid_in & ready_out;
    assign pop       = valid_out & ready_in;

    // A bypassed word is consumed straight from the inputs and never stored.
    assign wr_en = push & ~bypass;
    assign rd_en = pop & ~bypass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (resteer) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                tail <= tail + PTR_W'(1);
            end
            if (rd_en) begin
                head <= head + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_instr[tail] <= instr_in;
            mem_pc[tail]    <= pc_in;
            mem_exc[tail]   <= exception_in;
        end
    end

    always_comb begin
        instr_out     = '0;
        pc_out        = '0;
        exception_out = 1'b0;
        if (bypass) begin
            instr_out     = instr_in;
            pc_out        = pc_in;
            exception_out = exception_in;
        end else if (valid_out) begin
            instr_out     = mem_instr[head];
            pc_out        = mem_pc[head];
            exception_out = mem_exc[head];
        end
    end

    assign is_compressed_out = valid_out & (instr_out[1:0] != 2'b11);
    assign count             = count_q;

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: queue-based reference model checked every cycle plus directed literal checks.
// Define FETCH_IQ_BYPASS_EN for both files to exercise the bypass path.
module tb_fetch_instr_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef FETCH_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            exc;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             resteer = 1'b0;
  logic             valid_in = 1'b0;
  logic [XLEN-1:0]  instr_in = '0;
  logic [XLEN-1:0]  pc_in = '0;
  logic             exception_in = 1'b0;
  logic             ready_in = 1'b0;
  logic             ready_out;
  logic             valid_out;
  logic [XLEN-1:0]  instr_out;
  logic [XLEN-1:0]  pc_out;
  logic             exception_out;
  logic             is_compressed_out;
  logic [CNT_W-1:0] count;

  fetch_instr_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .resteer           (resteer),
    .valid_in          (valid_in),
    .instr_in          (instr_in),
    .pc_in             (pc_in),
    .exception_in      (exception_in),
    .ready_out         (ready_out),
    .valid_out         (valid_out),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .exception_out     (exception_out),
    .is_compressed_out (is_compressed_out),
    .ready_in          (ready_in),
    .count             (count)
  );

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: model contents of the queue, oldest entry at index 0
  ent_t exp_q[$];

  initial begin : compare
    logic            byp;
    logic            e_valid;
    logic            e_ready;
    logic [XLEN-1:0] e_instr;
    logic [XLEN-1:0] e_pc;
    logic            e_exc;
    logic            pop_m;
    logic            push_m;
    ent_t            e;
    while (!done) begin
      @(negedge clk);
      if (done) break;
      if (!rst) exp_q.delete();
      byp     = BYP && rst && exp_q.size() == 0 && valid_in && ready_in && !resteer;
      e_valid = byp || (exp_q.size() != 0 && !resteer);
      e_ready = (exp_q.size() != DEPTH) && !resteer;
      e_instr = '0;
      e_pc    = '0;
      e_exc   = 1'b0;
      if (byp) begin
        e_instr = instr_in;
        e_pc    = pc_in;
        e_exc   = exception_in;
      end else if (e_valid) begin
        e_instr = exp_q[0].instr;
        e_pc    = exp_q[0].pc;
        e_exc   = exp_q[0].exc;
      end
      chk("m_valid_out", XLEN'(valid_out), XLEN'(e_valid));
      chk("m_ready_out", XLEN'(ready_out), XLEN'(e_ready));
      chk("m_count", XLEN'(count), XLEN'(exp_q.size()));
      chk("m_instr_out", instr_out, e_instr);
      chk("m_pc_out", pc_out, e_pc);
      chk("m_exception_out", XLEN'(exception_out), XLEN'(e_exc));
      chk("m_is_compressed", XLEN'(is_compressed_out),
          XLEN'(e_valid && (e_instr % 4 != 3)));
      // advance the model to what the next rising edge should produce
      if (rst) begin
        if (resteer) begin
          exp_q.delete();
        end else if (!byp) begin
          pop_m  = exp_q.size() != 0 && ready_in;
          push_m = valid_in && exp_q.size() != DEPTH;
          if (pop_m) void'(exp_q.pop_front());
          if (push_m) begin
            e.instr = instr_in;
            e.pc    = pc_in;
            e.exc   = exception_in;
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in     = 1'b0;
    ready_in     = 1'b0;
    resteer      = 1'b0;
    exception_in = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [XLEN-1:0] base_pc, input logic [XLEN-1:0] instr);
    ready_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      pc_in    = base_pc + XLEN'(4 * i);
      instr_in = instr + XLEN'(i << 7);
      cyc();
    end
    valid_in = 1'b0;
  endtask

  task automatic drain(input int n);
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (n) cyc();
    ready_in = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    // 1. reset with random data inputs
    idle();
    for (int i = 0; i < 4; i++) begin
      valid_in     = 1'($urandom_range(0, 1));
      instr_in     = $urandom();
      pc_in        = $urandom();
      exception_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_valid_out", XLEN'(valid_out), 0);
      chk("rst_ready_out", XLEN'(ready_out), 1);
      chk("rst_count", XLEN'(count), 0);
      cyc();
    end
    idle();
    rst = 1'b1;
    cyc();
    valid_in = 1'b1;
    pc_in    = 32'h0000_1000;
    instr_in = 32'h0000_0013;
    cyc();
    valid_in = 1'b0;
    @(negedge clk);
    chk("t1_valid_out", XLEN'(valid_out), 1);
    chk("t1_pc_out", pc_out, 32'h0000_1000);
    chk("t1_instr_out", instr_out, 32'h0000_0013);
    chk("t1_is_compressed", XLEN'(is_compressed_out), 0);
    cyc();
    drain(1);

    // 2. fill, drop a ninth word, drain in order
    push_n(8, 32'h0000_2000, 32'h0000_0093);
    valid_in = 1'b1;
    pc_in    = 32'h0000_2020;
    @(negedge clk);
    chk("t2_count_full", XLEN'(count), 8);
    chk("t2_ready_full", XLEN'(ready_out), 0);
    cyc();
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_drain_pc", pc_out, 32'h0000_2000 + XLEN'(4 * i));
      cyc();
    end
    ready_in = 1'b0;
    @(negedge clk);
    chk("t2_count_empty", XLEN'(count), 0);
    chk("t2_valid_empty", XLEN'(valid_out), 0);
    cyc();

    // 3. simultaneous push and pop across pointer wrap
    push_n(3, 32'h0000_3000, 32'h0000_0113);
    ready_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1;
      pc_in    = 32'h0000_300C + XLEN'(4 * i);
      instr_in = 32'h0000_0113 + XLEN'((i + 3) << 7);
      @(negedge clk);
      chk("t3_count_steady", XLEN'(count), 3);
      chk("t3_pc_order", pc_out, 32'h0000_3000 + XLEN'(4 * i));
      cyc();
    end
    drain(3);

    // 4. full plus pop: pop happens, push is refused
    push_n(8, 32'h0000_5000, 32'h0000_0193);
    valid_in = 1'b1;
    pc_in    = 32'h0000_5100;
    ready_in = 1'b1;
    @(negedge clk);
    chk("t4_ready_full", XLEN'(ready_out), 0);
    chk("t4_valid_full", XLEN'(valid_out), 1);
    chk("t4_head_pc", pc_out, 32'h0000_5000);
    cyc();
    idle();
    @(negedge clk);
    chk("t4_count_after", XLEN'(count), 7);
    chk("t4_new_head", pc_out, 32'h0000_5004);
    cyc();
    drain(7);

    // 5. resteer wins over push and pop
    push_n(5, 32'h0000_6000, 32'h0000_0213);
    resteer  = 1'b1;
    valid_in = 1'b1;
    ready_in = 1'b1;
    pc_in    = 32'h0000_6100;
    @(negedge clk);
    chk("t5_valid_resteer", XLEN'(valid_out), 0);
    chk("t5_ready_resteer", XLEN'(ready_out), 0);
    cyc();
    idle();
    @(negedge clk);
    chk("t5_count_flushed", XLEN'(count), 0);
    cyc();
    push_n(1, 32'h0000_4000, 32'h0000_0013);
    @(negedge clk);
    chk("t5_only_pc", pc_out, 32'h0000_4000);
    chk("t5_only_count", XLEN'(count), 1);
    cyc();
    drain(1);

    // 6. exception flag and compressed word
    exception_in = 1'b1;
    push_n(1, 32'h0000_7000, 32'h0000_4501);
    exception_in = 1'b0;
    @(negedge clk);
    chk("t6_is_compressed", XLEN'(is_compressed_out), 1);
    chk("t6_exception", XLEN'(exception_out), 1);
    chk("t6_instr", instr_out, 32'h0000_4501);
    cyc();
    drain(1);
`ifdef FETCH_IQ_BYPASS_EN
    valid_in = 1'b1;
    ready_in = 1'b1;
    pc_in    = 32'h0000_5000;
    instr_in = 32'h0000_4501;
    @(negedge clk);
    chk("t6_byp_valid", XLEN'(valid_out), 1);
    chk("t6_byp_pc", pc_out, 32'h0000_5000);
    chk("t6_byp_count", XLEN'(count), 0);
    cyc();
    idle();
    @(negedge clk);
    chk("t6_byp_count_next", XLEN'(count), 0);
    cyc();
`endif

    // asynchronous reset in the middle of traffic discards everything
    push_n(3, 32'h0000_8000, 32'h0000_0293);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_count", XLEN'(count), 0);
    chk("rst_mid_valid", XLEN'(valid_out), 0);
    cyc();
    rst = 1'b1;
    cyc();

    // random traffic checked only by the model
    for (int i = 0; i < 60; i++) begin
      valid_in     = 1'($urandom_range(0, 1));
      ready_in     = 1'($urandom_range(0, 1));
      resteer      = ($urandom_range(0, 15) == 0);
      instr_in     = $urandom();
      pc_in        = $urandom();
      exception_in = 1'($urandom_range(0, 1));
      cyc();
    end
    idle();
    @(negedge clk);
    done = 1'b1;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
